// File: rtl/comm_cmd_pkg.sv
// rtl/comm_cmd_pkg.sv - shared states, header byte and frame-length constants; CMD_CHECKSUM_EN adds a checksum byte
package comm_cmd_pkg;

  typedef enum logic [1:0] {
    S_IDLE   = 2'd0,
    S_SEND   = 2'd1,
    S_WAITTX = 2'd2,
    S_GUARD  = 2'd3
  } state_e;

  localparam logic [7:0] HEADER_BYTE = 8'hA5;

  // Serial bits per byte on the wire: start, 8 data, stop.
  localparam int FRAME_BITS = 10;

`ifdef CMD_CHECKSUM_EN
  localparam int FRAME_BYTES = 3;
`else
  localparam int FRAME_BYTES = 2;
`endif

  function automatic logic [7:0] code_byte(input logic [2:0] cmd);
    return {5'b00000, cmd};
  endfunction

  // Byte idx of the frame for a given command: header, code, then checksum.
  function automatic logic [7:0] frame_byte(input logic [1:0] idx, input logic [2:0] cmd);
    case (idx)
      2'd0:    return HEADER_BYTE;
      2'd1:    return code_byte(cmd);
      default: return HEADER_BYTE ^ code_byte(cmd);
    endcase
  endfunction

endpackage

// File: rtl/uart_tx_byte.sv
// rtl/uart_tx_byte.sv - 8N1 byte serializer; done fires one cycle early so the next byte can follow without a gap
module uart_tx_byte #(
  parameter int CLK_DIV = 434
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       load,
  input  logic [7:0] data,
  output logic       tx,
  output logic       busy,
  output logic       done
);
  import comm_cmd_pkg::*;

  localparam int FRAME_CYC = FRAME_BITS * CLK_DIV;
  localparam int CW = $clog2(FRAME_CYC);
  localparam int DW = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;

  logic          busy_q, busy_d;
  logic [9:0]    shift_q, shift_d;
  logic [CW-1:0] cyc_q, cyc_d;
  logic [DW-1:0] div_q, div_d;
  logic          last_cycle;
  logic          accept;

  // A new byte may be accepted while idle or during the final stop-bit cycle.
  assign last_cycle = busy_q && (cyc_q == CW'(FRAME_CYC - 1));
  assign accept     = load && (!busy_q || last_cycle);
  assign done       = busy_q && (cyc_q == CW'(FRAME_CYC - 2));
  assign busy       = busy_q;
  assign tx         = busy_q ? shift_q[0] : 1'b1;

  // Bit timing: shift the frame out LSB first, one bit every CLK_DIV cycles.
  always_comb begin
    busy_d  = busy_q;
    shift_d = shift_q;
    cyc_d   = cyc_q;
    div_d   = div_q;
    if (accept) begin
      busy_d  = 1'b1;
      shift_d = {1'b1, data, 1'b0};
      cyc_d   = '0;
      div_d   = '0;
    end else if (busy_q) begin
      if (last_cycle) begin
        busy_d  = 1'b0;
        shift_d = '1;
        cyc_d   = '0;
        div_d   = '0;
      end else begin
        cyc_d = cyc_q + CW'(1);
        if (div_q == DW'(CLK_DIV - 1)) begin
          div_d   = '0;
          shift_d = {1'b1, shift_q[9:1]};
        end else begin
          div_d = div_q + DW'(1);
        end
      end
    end
  end

  // Serializer registers with synchronous active-low reset.
  always_ff @(posedge clk) begin
    if (!rst) begin
      busy_q  <= 1'b0;
      shift_q <= '1;
      cyc_q   <= '0;
      div_q   <= '0;
    end else begin
      busy_q  <= busy_d;
      shift_q <= shift_d;
      cyc_q   <= cyc_d;
      div_q   <= div_d;
    end
  end

endmodule

// File: rtl/comm_cmd_responder.sv
// rtl/comm_cmd_responder.sv - command-to-serial-frame responder with busy guard; CMD_CHECKSUM_EN selects 3-byte frames
module comm_cmd_responder #(
  parameter int CLK_DIV      = 434,
  parameter int GUARD_CYCLES = 2000
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       start,
  input  logic [2:0] command_1,
  output logic       ready_command,
  output logic       bussyComunicaciones,
  output logic       tx
);
  import comm_cmd_pkg::*;

  localparam int GW = (GUARD_CYCLES > 0) ? $clog2(GUARD_CYCLES + 1) : 1;

  state_e        state_q, state_d;
  logic          start_q, start_d;
  logic [2:0]    cmd_q, cmd_d;
  logic          ready_q, ready_d;
  logic          busy_q, busy_d;
  logic [1:0]    byte_idx_q, byte_idx_d;
  logic          tail_q, tail_d;
  logic [GW-1:0] guard_q, guard_d;

  logic          byte_load;
  logic [7:0]    byte_data;
  logic          byte_busy;
  logic          byte_done;
  logic          launch;

  // A launch needs a rising start or a command different from the last one launched.
  assign launch = (state_q == S_IDLE) && start && (!start_q || (command_1 != cmd_q)) && !byte_busy;
  assign byte_data = frame_byte(byte_idx_q, cmd_q);

  assign ready_command       = ready_q;
  assign bussyComunicaciones = busy_q;

  uart_tx_byte #(
    .CLK_DIV(CLK_DIV)
  ) u_tx (
    .clk  (clk),
    .rst  (rst),
    .load (byte_load),
    .data (byte_data),
    .tx   (tx),
    .busy (byte_busy),
    .done (byte_done)
  );

  // Frame sequencing: launch, feed bytes back-to-back, release ready, then hold busy for the guard.
  always_comb begin
    state_d    = state_q;
    start_d    = start;
    cmd_d      = cmd_q;
    ready_d    = ready_q;
    busy_d     = busy_q;
    byte_idx_d = byte_idx_q;
    tail_d     = tail_q;
    guard_d    = guard_q;
    byte_load  = 1'b0;
    case (state_q)
      S_IDLE: begin
        if (launch) begin
          state_d    = S_SEND;
          cmd_d      = command_1;
          ready_d    = 1'b0;
          busy_d     = 1'b1;
          byte_idx_d = '0;
          tail_d     = 1'b0;
        end
      end
      S_SEND: begin
        // Commands 4-7 carry no frame: one cycle of not-ready, then straight to the guard.
        if (cmd_q[2]) begin
          state_d = S_GUARD;
          ready_d = 1'b1;
          guard_d = GW'(GUARD_CYCLES);
        end else begin
          byte_load = 1'b1;
          state_d   = S_WAITTX;
        end
      end
      S_WAITTX: begin
        // done comes one cycle before the stop bit ends; tail_q covers that final cycle.
        if (tail_q) begin
          tail_d  = 1'b0;
          state_d = S_GUARD;
          ready_d = 1'b1;
          guard_d = GW'(GUARD_CYCLES);
        end else if (byte_done) begin
          if (byte_idx_q == 2'(FRAME_BYTES - 1)) begin
            tail_d = 1'b1;
          end else begin
            byte_idx_d = byte_idx_q + 2'd1;
            state_d    = S_SEND;
          end
        end
      end
      S_GUARD: begin
        if (guard_q <= GW'(1)) begin
          state_d = S_IDLE;
          busy_d  = 1'b0;
          guard_d = '0;
        end else begin
          guard_d = guard_q - GW'(1);
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

  // Handshake and sequencer registers with synchronous active-low reset.
  always_ff @(posedge clk) begin
    if (!rst) begin
      state_q    <= S_IDLE;
      start_q    <= 1'b0;
      cmd_q      <= 3'd0;
      ready_q    <= 1'b1;
      busy_q     <= 1'b0;
      byte_idx_q <= '0;
      tail_q     <= 1'b0;
      guard_q    <= '0;
    end else begin
      state_q    <= state_d;
      start_q    <= start_d;
      cmd_q      <= cmd_d;
      ready_q    <= ready_d;
      busy_q     <= busy_d;
      byte_idx_q <= byte_idx_d;
      tail_q     <= tail_d;
      guard_q    <= guard_d;
    end
  end

endmodule

// File: tb/tb_comm_cmd_responder.sv
// tb/tb_comm_cmd_responder.sv - self-checking bench for comm_cmd_responder (CMD_CHECKSUM_EN selects 3-byte model)
module tb_comm_cmd_responder;

  localparam int CD = 4;
  localparam int GD = 16;
`ifdef CMD_CHECKSUM_EN
  localparam int NBYTES = 3;
`else
  localparam int NBYTES = 2;
`endif

  logic       clk = 1'b0;
  logic       rst;
  logic       start;
  logic [2:0] command_1;
  logic       ready;
  logic       busy;
  logic       tx;

  int checks = 0;
  int errors = 0;

  logic cap_tx  [0:255];
  logic cap_rdy [0:255];
  logic cap_bsy [0:255];

  comm_cmd_responder #(
    .CLK_DIV(CD),
    .GUARD_CYCLES(GD)
  ) dut (
    .clk                 (clk),
    .rst                 (rst),
    .start               (start),
    .command_1           (command_1),
    .ready_command       (ready),
    .bussyComunicaciones (busy),
    .tx                  (tx)
  );

  always #5 clk = ~clk;

  // Expected line level s cycles after the launch edge.
  function automatic logic model_tx(input int cmd, input int s);
    int nb, p, b, k;
    logic [7:0] byt;
    nb = (cmd < 4) ? NBYTES : 0;
    if (s < 1 || s > nb * 10 * CD) return 1'b1;
    p = s - 1;
    b = p / (10 * CD);
    k = (p % (10 * CD)) / CD;
    byt = (b == 0) ? 8'hA5 : (b == 1) ? 8'(cmd) : (8'hA5 ^ 8'(cmd));
    if (k == 0) return 1'b0;
    if (k == 9) return 1'b1;
    return byt[k-1];
  endfunction

  function automatic int exp_rise(input int cmd);
    return (cmd < 4) ? NBYTES * 10 * CD + 1 : 1;
  endfunction

  function automatic int exp_fall(input int cmd);
    return exp_rise(cmd) + GD;
  endfunction

  function automatic int tx_errs(input int cmd, input int n);
    int e = 0;
    for (int s = 0; s <= n; s++) if (cap_tx[s] !== model_tx(cmd, s)) e++;
    return e;
  endfunction

  function automatic int rise_of(input int n);
    for (int s = 0; s <= n; s++) if (cap_rdy[s] === 1'b1) return s;
    return -1;
  endfunction

  function automatic int fall_of(input int n);
    for (int s = 1; s <= n; s++) if (cap_bsy[s] === 1'b0) return s;
    return -1;
  endfunction

  // Samples n+1 cycles (s=0 follows the next rising edge); optionally changes command_1 after sample chg_s.
  task automatic capture(input int n, input int chg_s, input logic [2:0] chg_val);
    for (int s = 0; s <= n; s++) begin
      @(negedge clk);
      cap_tx[s]  = tx;
      cap_rdy[s] = ready;
      cap_bsy[s] = busy;
      if (s == chg_s) command_1 = chg_val;
    end
  endtask

  task automatic test_reset;
    rst = 1'b0; start = 1'b0; command_1 = 3'd0;
    repeat (3) @(negedge clk);
    checks += 3;
    if (ready !== 1'b1) begin errors++; $display("FAIL reset_ready: got %b expected 1", ready); end
    if (busy !== 1'b0) begin errors++; $display("FAIL reset_busy: got %b expected 0", busy); end
    if (tx !== 1'b1) begin errors++; $display("FAIL reset_tx: got %b expected 1", tx); end
    rst = 1'b1;
  endtask

  task automatic test_single;
    int n;
    n = exp_fall(2);
    start = 1'b1; command_1 = 3'd2;
    capture(n, -1, 3'd0);
    checks += 4;
    if (cap_rdy[0] !== 1'b0 || cap_bsy[0] !== 1'b1) begin errors++; $display("FAIL single_launch: ready=%b busy=%b expected 0/1", cap_rdy[0], cap_bsy[0]); end
    if (tx_errs(2, n) != 0) begin errors++; $display("FAIL single_tx: %0d bad samples expected 0", tx_errs(2, n)); end
    if (rise_of(n) != exp_rise(2)) begin errors++; $display("FAIL single_ready_rise: at %0d expected %0d", rise_of(n), exp_rise(2)); end
    if (fall_of(n) != n) begin errors++; $display("FAIL single_busy_fall: at %0d expected %0d", fall_of(n), n); end
  endtask

  task automatic test_held_sequence;
    int n, bad;
    command_1 = 3'd0;
    for (int c = 0; c < 4; c++) begin
      n = exp_fall(c);
      capture(n, (c < 3) ? exp_rise(c) : -1, 3'(c + 1));
      checks += 4;
      if (cap_rdy[0] !== 1'b0 || cap_bsy[0] !== 1'b1) begin errors++; $display("FAIL held%0d_launch: ready=%b busy=%b expected 0/1", c, cap_rdy[0], cap_bsy[0]); end
      if (tx_errs(c, n) != 0) begin errors++; $display("FAIL held%0d_tx: %0d bad samples expected 0", c, tx_errs(c, n)); end
      if (rise_of(n) != exp_rise(c)) begin errors++; $display("FAIL held%0d_ready_rise: at %0d expected %0d", c, rise_of(n), exp_rise(c)); end
      if (fall_of(n) != n) begin errors++; $display("FAIL held%0d_busy_fall: at %0d expected %0d", c, fall_of(n), n); end
    end
    capture(40, -1, 3'd0);
    bad = 0;
    for (int s = 0; s <= 40; s++) if (cap_rdy[s] !== 1'b1 || cap_bsy[s] !== 1'b0 || cap_tx[s] !== 1'b1) bad++;
    checks++;
    if (bad != 0) begin errors++; $display("FAIL held_no_repeat: %0d active samples expected 0", bad); end
  endtask

  task automatic test_invalid;
    int n;
    n = exp_fall(6);
    start = 1'b0;
    repeat (2) @(negedge clk);
    start = 1'b1; command_1 = 3'd6;
    capture(n, -1, 3'd0);
    checks += 4;
    if (cap_rdy[0] !== 1'b0 || cap_bsy[0] !== 1'b1) begin errors++; $display("FAIL invalid_launch: ready=%b busy=%b expected 0/1", cap_rdy[0], cap_bsy[0]); end
    if (tx_errs(6, n) != 0) begin errors++; $display("FAIL invalid_tx: %0d bad samples expected 0", tx_errs(6, n)); end
    if (rise_of(n) != 1) begin errors++; $display("FAIL invalid_ready_rise: at %0d expected 1", rise_of(n)); end
    if (fall_of(n) != GD + 1) begin errors++; $display("FAIL invalid_busy_fall: at %0d expected %0d", fall_of(n), GD + 1); end
  endtask

  task automatic test_midframe_change;
    int n, c;
    start = 1'b0;
    repeat (2) @(negedge clk);
    start = 1'b1; command_1 = 3'd1;
    for (int f = 0; f < 2; f++) begin
      c = f + 1;
      n = exp_fall(c);
      capture(n, (f == 0) ? 30 : -1, 3'd2);
      checks += 4;
      if (cap_rdy[0] !== 1'b0 || cap_bsy[0] !== 1'b1) begin errors++; $display("FAIL change%0d_launch: ready=%b busy=%b expected 0/1", f, cap_rdy[0], cap_bsy[0]); end
      if (tx_errs(c, n) != 0) begin errors++; $display("FAIL change%0d_tx: %0d bad samples expected 0", f, tx_errs(c, n)); end
      if (rise_of(n) != exp_rise(c)) begin errors++; $display("FAIL change%0d_ready_rise: at %0d expected %0d", f, rise_of(n), exp_rise(c)); end
      if (fall_of(n) != n) begin errors++; $display("FAIL change%0d_busy_fall: at %0d expected %0d", f, fall_of(n), n); end
    end
  endtask

  task automatic test_reset_midframe;
    int n;
    command_1 = 3'd1;
    capture(25, -1, 3'd0);
    rst = 1'b0;
    @(negedge clk);
    checks += 3;
    if (tx !== 1'b1) begin errors++; $display("FAIL rstmid_tx: got %b expected 1", tx); end
    if (ready !== 1'b1) begin errors++; $display("FAIL rstmid_ready: got %b expected 1", ready); end
    if (busy !== 1'b0) begin errors++; $display("FAIL rstmid_busy: got %b expected 0", busy); end
    rst = 1'b1;
    n = exp_fall(1);
    capture(n, -1, 3'd0);
    checks += 4;
    if (cap_rdy[0] !== 1'b0 || cap_bsy[0] !== 1'b1) begin errors++; $display("FAIL rstmid_relaunch: ready=%b busy=%b expected 0/1", cap_rdy[0], cap_bsy[0]); end
    if (tx_errs(1, n) != 0) begin errors++; $display("FAIL rstmid_tx_frame: %0d bad samples expected 0", tx_errs(1, n)); end
    if (rise_of(n) != exp_rise(1)) begin errors++; $display("FAIL rstmid_ready_rise: at %0d expected %0d", rise_of(n), exp_rise(1)); end
    if (fall_of(n) != n) begin errors++; $display("FAIL rstmid_busy_fall: at %0d expected %0d", fall_of(n), n); end
  endtask

  task automatic test_cmd3_frame;
    int n;
    n = exp_fall(3);
    command_1 = 3'd3;
    capture(n, -1, 3'd0);
    checks += 3;
    if (tx_errs(3, n) != 0) begin errors++; $display("FAIL cmd3_tx: %0d bad samples expected 0", tx_errs(3, n)); end
    if (rise_of(n) != exp_rise(3)) begin errors++; $display("FAIL cmd3_ready_rise: at %0d expected %0d", rise_of(n), exp_rise(3)); end
    if (fall_of(n) != n) begin errors++; $display("FAIL cmd3_busy_fall: at %0d expected %0d", fall_of(n), n); end
  endtask

  task automatic test_random;
    int c, n, last;
    last = 3;
    for (int it = 0; it < 10; it++) begin
      c = int'($urandom_range(0, 7));
      if ($urandom_range(0, 1) == 0 || c == last) begin
        start = 1'b0;
        repeat ($urandom_range(1, 3)) @(negedge clk);
      end
      start = 1'b1; command_1 = 3'(c);
      n = exp_fall(c);
      capture(n, -1, 3'd0);
      checks += 4;
      if (cap_rdy[0] !== 1'b0 || cap_bsy[0] !== 1'b1) begin errors++; $display("FAIL rand%0d_launch cmd %0d: ready=%b busy=%b expected 0/1", it, c, cap_rdy[0], cap_bsy[0]); end
      if (tx_errs(c, n) != 0) begin errors++; $display("FAIL rand%0d_tx cmd %0d: %0d bad samples expected 0", it, c, tx_errs(c, n)); end
      if (rise_of(n) != exp_rise(c)) begin errors++; $display("FAIL rand%0d_ready_rise cmd %0d: at %0d expected %0d", it, c, rise_of(n), exp_rise(c)); end
      if (fall_of(n) != n) begin errors++; $display("FAIL rand%0d_busy_fall cmd %0d: at %0d expected %0d", it, c, fall_of(n), n); end
      last = c;
    end
  endtask

  initial begin
    test_reset();
    test_single();
    test_held_sequence();
    test_invalid();
    test_midframe_change();
    test_reset_midframe();
    test_cmd3_frame();
    test_random();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/comm_cmd_responder.md
COMM_CMD_RESPONDER -- requirements
Module: comm_cmd_responder

Interface
REQ-001 SHALL have parameter CLK_DIV, default 434, clock cycles per serial bit (50 MHz / 115200 baud).
REQ-002 SHALL have parameter GUARD_CYCLES, default 2000, idle cycles during which busy is held after the last frame.
REQ-003 SHALL have port clk  input  1  single system clock; all logic on rising edge.
REQ-004 SHALL have port rst  input  1  reset; synchronous, active-low.
REQ-005 SHALL have port start  input  1  level request from the command controller; held high across consecutive commands.
REQ-006 SHALL have port command_1  input  3  command index, valid while start=1.
REQ-007 SHALL have port ready_command  output  1  1 = idle or command done; 0 = command executing.
REQ-008 SHALL have port bussyComunicaciones  output  1  1 = frame in flight or guard period running.
REQ-009 SHALL have port tx  output  1  serial line, 8N1, LSB first, idle high.

Function
REQ-010 SHALL register start and the last launched command as start_q and cmd_q.
REQ-011 SHALL launch when in S_IDLE with start=1 and either start_q=0 or command_1≠cmd_q (rising start, or a new command while start is held).
REQ-012 SHALL NOT relaunch a command equal to cmd_q while start stays high.
REQ-013 SHALL use states S_IDLE, S_SEND, S_WAITTX, S_GUARD: IDLE→SEND on launch; SEND→WAITTX after loading a byte; WAITTX→SEND while bytes remain; WAITTX→GUARD after the last stop bit; GUARD→IDLE when the guard counter reaches 0.
REQ-014 SHALL drive ready_command=0 and bussyComunicaciones=1 from the clock edge that samples the launch condition.
REQ-015 SHALL send, for valid commands 0-3, a frame of header byte 8'hA5 followed by code byte {5'b00000, command_1}, with the command captured at launch.
REQ-016 SHALL make each byte take exactly 10*CLK_DIV cycles (start bit 0, 8 data bits, stop bit 1), with bytes sent back-to-back and no idle bits between them.
REQ-017 SHALL return ready_command to 1 on the edge following completion of the last stop bit, and keep it at 1 during S_GUARD.
REQ-018 SHALL, in S_GUARD, count down GUARD_CYCLES and hold bussyComunicaciones=1; it SHALL drop to 0 on the edge that enters S_IDLE.
REQ-019 SHALL handle commands 4-7 as follows: no bytes sent, tx stays 1, ready_command=0 for exactly one cycle, then S_GUARD entered.
REQ-020 SHALL complete a frame even if start drops or command_1 changes mid-frame; a change seen mid-frame is launched from S_IDLE if still present.
REQ-021 SHALL ignore launch conditions in S_GUARD until S_IDLE is reached.

Reset
REQ-022 SHALL, on rst=0 at a clock edge, set state=S_IDLE, ready_command=1, bussyComunicaciones=0, tx=1, start_q=0, cmd_q=3'd0, and clear all counters.
REQ-023 SHALL, on reset mid-frame, abandon the frame: tx=1 from the next edge, and no resume after reset.

Configuration
REQ-024 SHALL, with CMD_CHECKSUM_EN defined, append a third byte equal to 8'hA5 XOR code byte, giving a valid frame of 30*CLK_DIV cycles.
REQ-025 SHALL, without CMD_CHECKSUM_EN, send the two-byte frame only (20*CLK_DIV cycles); all other behaviour is identical.

Structure
REQ-026 SHALL place the state encodings, the header constant 8'hA5 and the frame-length constants in shared package comm_cmd_pkg.
REQ-027 SHALL put byte serialization in sub-module uart_tx_byte (load strobe, 8-bit data, busy/done outputs, CLK_DIV parameter); frame sequencing and the handshake stay in comm_cmd_responder.

Verification (CLK_DIV=4, GUARD_CYCLES=16, checksum off unless stated)
REQ-028 SHALL cover: rst low 3 cycles → ready=1, busy=0, tx=1; start 0→1 with command_1=2 → ready=0 next edge, tx shows A5 then 02 over 80 cycles, ready=1 at cycle 81, busy=0 16 cycles later.
REQ-029 SHALL cover: start held at 1, command_1 stepped 0,1,2,3 after each ready=1 → four frames with code bytes 00,01,02,03; no frame repeated while command_1 is unchanged.
REQ-030 SHALL cover: command_1=6 with start rising → ready low exactly 1 cycle, tx constant 1, busy high for 17 cycles.
REQ-031 SHALL cover: rst asserted at cycle 25 of a frame → tx=1, ready=1, busy=0 next edge; start kept high afterwards → new frame launches only after start_q or cmd_q changes (start_q cleared, so it relaunches).
REQ-032 SHALL cover: CMD_CHECKSUM_EN defined, command_1=3 → bytes A5, 03, A6 over 120 cycles.
REQ-033 SHALL cover: command_1 changed 1→2 mid-frame → frame completes with code 01, then a second frame with 02 follows after the guard period.
